// File: rtl/pu_stream_write_buffer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the PU write buffer (master)
// and the DDR interconnect (slave).
interface pu_stream_write_buffer_if #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ADDR_W = 32
);
  logic                  m_awvalid;
  logic                  m_awready;
  logic [AXI_ADDR_W-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [AXI_DATA_W-1:0] m_wdata;
  logic                  m_wlast;
  logic                  m_bvalid;
  logic                  m_bready;

  modport master (
    output m_awvalid, m_awaddr, m_awlen,
    input  m_awready,
    output m_wvalid, m_wdata, m_wlast,
    input  m_wready,
    input  m_bvalid,
    output m_bready
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_awlen,
    output m_awready,
    input  m_wvalid, m_wdata, m_wlast,
    output m_wready,
    output m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/pu_stream_write_buffer.sv
// Buffers the PU output stream in a FIFO and drains it to DDR as AXI4 INCR
// write bursts starting at a configured base address; pulses done after the last B.
module pu_stream_write_buffer #(
  parameter int AXI_DATA_W   = 64,
  parameter int AXI_ADDR_W   = 32,
  parameter int FIFO_ADDR_W  = 6,
  parameter int BURST_LEN    = 16,
  parameter int READY_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cfg_start,
  input  logic [AXI_ADDR_W-1:0] cfg_base_addr,
  input  logic [31:0]           cfg_num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,

  output logic                  stream_write_ready,
  input  logic                  stream_write_req,
  input  logic [AXI_DATA_W-1:0] stream_write_data,

  pu_stream_write_buffer_if.master axi
);

  localparam int DEPTH      = 1 << FIFO_ADDR_W;
  localparam int CNT_W      = FIFO_ADDR_W + 1;
  localparam int BYTE_SHIFT = $clog2(AXI_DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_FIN
  } state_t;

  // ------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------
  logic [AXI_DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_reg;
  logic [FIFO_ADDR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       count_next;
  logic                   ready_reg;
  logic                   fifo_full;
  logic                   push_ok;
  logic                   push_drop;
  logic                   pop;

  logic                   wvalid_reg;

  assign fifo_full = (count_reg == CNT_W'(DEPTH));
  assign pop       = wvalid_reg && axi.m_wready;
  // A full FIFO that is popping in the same cycle frees the slot being written.
  assign push_ok   = stream_write_req && (!fifo_full || pop);
  assign push_drop = stream_write_req && fifo_full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset; the head is read combinationally so a beat pushed
  // at one edge can drive m_wdata in the very next cycle.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= stream_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + FIFO_ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + FIFO_ADDR_W'(1);
      end
      count_reg <= count_next;
      // Judged on the post-edge count so a PU with one cycle of req latency
      // can land at most one more beat after ready falls.
      ready_reg <= (count_next <= CNT_W'(DEPTH - READY_MARGIN));
    end
  end

  assign stream_write_ready = ready_reg;

  // ------------------------------------------------------------------
  // Burst controller
  // ------------------------------------------------------------------
  state_t                state_reg;
  logic [AXI_ADDR_W-1:0] addr_reg;
  logic [31:0]           remaining_reg;
  logic [7:0]            beat_cnt_reg;
  logic [8:0]            burst;

  logic                  busy_reg;
  logic                  done_reg;
  logic                  overflow_reg;
  logic                  awvalid_reg;
  logic [AXI_ADDR_W-1:0] awaddr_reg;
  logic [7:0]            awlen_reg;
  logic                  wlast_reg;
  logic                  bready_reg;

  assign burst = (remaining_reg >= 32'(BURST_LEN)) ? 9'(BURST_LEN) : remaining_reg[8:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      beat_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      awvalid_reg   <= 1'b0;
      awaddr_reg    <= '0;
      awlen_reg     <= '0;
      wvalid_reg    <= 1'b0;
      wlast_reg     <= 1'b0;
      bready_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // A drop in the same cycle as an accepted start still leaves the flag set.
      if (push_drop) begin
        overflow_reg <= 1'b1;
      end else if (state_reg == S_IDLE && cfg_start) begin
        overflow_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (cfg_start) begin
            addr_reg      <= cfg_base_addr;
            remaining_reg <= cfg_num_beats;
            busy_reg      <= 1'b1;
            state_reg     <= (cfg_num_beats == 32'd0) ? S_FIN : S_FILL;
          end
        end

        S_FILL: begin
          if (32'(count_reg) >= 32'(burst)) begin
            awvalid_reg <= 1'b1;
            awaddr_reg  <= addr_reg;
            awlen_reg   <= 8'(burst - 9'd1);
            state_reg   <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (axi.m_awready) begin
            awvalid_reg  <= 1'b0;
            addr_reg     <= addr_reg + (AXI_ADDR_W'(burst) << BYTE_SHIFT);
            beat_cnt_reg <= 8'(burst - 9'd1);
            wvalid_reg   <= 1'b1;
            wlast_reg    <= (burst == 9'd1);
            state_reg    <= S_DATA;
          end
        end

        S_DATA: begin
          if (axi.m_wready) begin
            remaining_reg <= remaining_reg - 32'd1;
            if (wlast_reg) begin
              wvalid_reg <= 1'b0;
              wlast_reg  <= 1'b0;
              bready_reg <= 1'b1;
              state_reg  <= S_RESP;
            end else begin
              beat_cnt_reg <= beat_cnt_reg - 8'd1;
              wlast_reg    <= (beat_cnt_reg == 8'd1);
            end
          end
        end

        S_RESP: begin
          if (axi.m_bvalid) begin
            bready_reg <= 1'b0;
            state_reg  <= (remaining_reg == 32'd0) ? S_FIN : S_FILL;
          end
        end

        S_FIN: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;

  assign axi.m_awvalid = awvalid_reg;
  assign axi.m_awaddr  = awaddr_reg;
  assign axi.m_awlen   = awlen_reg;
  assign axi.m_wvalid  = wvalid_reg;
  assign axi.m_wdata   = wvalid_reg ? mem[rd_ptr_reg] : '0;
  assign axi.m_wlast   = wlast_reg;
  assign axi.m_bready  = bready_reg;

endmodule

// File: doc/pu_stream_write_buffer.md
# pu_stream_write_buffer

Downstream stage of the PU loopback/compute controller. It accepts the PU's outgoing stream (`stream_write_req` / `stream_write_data`, where data is valid in the same cycle as req) into a FIFO and back-pressures the PU through `stream_write_ready`. It drains the FIFO to DDR as AXI4 INCR write bursts from a configured base address, then pulses `done` once the last write response has returned.

## Interface
Parameters:
- `AXI_DATA_W`, 64: stream and AXI data width; must be a power of two, at least 8.
- `AXI_ADDR_W`, 32: AXI address width.
- `FIFO_ADDR_W`, 6: FIFO depth is 2^FIFO_ADDR_W (64).
- `BURST_LEN`, 16: maximum beats per burst; must be at most 256 and at most the FIFO depth.
- `READY_MARGIN`, 2: free-slot margin that absorbs the PU's registered-req latency.

Ports (reset is `reset`, synchronous, active-high; clock is `clk`):
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `cfg_start`, input, 1: one-cycle pulse that latches the config and starts a transfer.
- `cfg_base_addr`, input, AXI_ADDR_W: byte address of the first beat. Must be aligned to BURST_LEN*AXI_DATA_W/8.
- `cfg_num_beats`, input, 32: total beats to write.
- `busy`, output, 1: high from accepted start until `done`.
- `done`, output, 1: one-cycle pulse after the final B response.
- `overflow`, output, 1: sticky; set on a push into a full FIFO; cleared by reset or an accepted start.
- `stream_write_ready`, output, 1: the buffer can take more PU beats.
- `stream_write_req`, input, 1: PU beat valid this cycle.
- `stream_write_data`, input, AXI_DATA_W: PU beat.
- `m_awvalid`, output, 1: AXI address channel valid.
- `m_awready`, input, 1: AXI address channel ready.
- `m_awaddr`, output, AXI_ADDR_W: AXI burst address.
- `m_awlen`, output, 8: AXI burst length (beats minus 1).
- `m_wvalid`, output, 1: AXI write data valid.
- `m_wready`, input, 1: AXI write data ready.
- `m_wdata`, output, AXI_DATA_W: AXI write data.
- `m_wlast`, output, 1: last beat of the burst.
- `m_bvalid`, input, 1: AXI write response valid.
- `m_bready`, output, 1: AXI write response ready.

## Operation
- FIFO
  - Push on every cycle where `stream_write_req` is high. The push happens regardless of state.
  - A push while `count == DEPTH` drops the data and sets `overflow`.
  - Pop on every accepted W beat (`m_wvalid && m_wready`).
  - Simultaneous push and pop: `count` is unchanged.
  - `stream_write_ready = (count <= DEPTH - READY_MARGIN)`, registered. It updates the cycle after `count` changes.
- Config and start
  - `cfg_start` is accepted only in IDLE; it is ignored while `busy`.
  - On acceptance, latch `addr = cfg_base_addr` and `remaining = cfg_num_beats`.
- State machine, with `burst = min(BURST_LEN, remaining)`:
  - **IDLE:** go to FILL on an accepted start. If `cfg_num_beats == 0`, go to FIN instead.
  - **FILL:** wait for `count >= burst`, then go to ADDR.
  - **ADDR:** `m_awvalid = 1`, `m_awaddr = addr`, `m_awlen = burst - 1`.
    - On `m_awready`, go to DATA.
    - Update `addr += burst*AXI_DATA_W/8`, with wrap-around modulo 2^AXI_ADDR_W.
    - Load `beat_cnt = burst - 1`.
  - **DATA:** `m_wvalid = 1`, `m_wdata` = FIFO head, `m_wlast = (beat_cnt == 0)`.
    - Each accepted beat decrements `beat_cnt` and `remaining`.
    - After the `m_wlast` beat is accepted, go to RESP.
  - **RESP:** `m_bready = 1`.
    - On `m_bvalid`: if `remaining == 0`, go to FIN; otherwise go to FILL.
    - BRESP is not checked.
  - **FIN:** `done = 1` for one cycle, then go to IDLE.
- `busy = (state != IDLE)`.
- `m_awvalid` and `m_wvalid` must not drop once raised until the handshake completes.
- Excess PU beats beyond `cfg_num_beats` stay in the FIFO for the next transfer. The FIFO is not flushed on start.

## Timing
- Reset values: `busy`, `done`, `overflow`, `m_awvalid`, `m_wvalid`, `m_wlast`, `m_bready` are 0; `m_awaddr`, `m_awlen`, `m_wdata` are 0; `stream_write_ready` is 1; FIFO `count` is 0; state is IDLE.
- Reset mid-transfer: aborts immediately and empties the FIFO. AXI signals drop without completing the handshake; the interconnect is reset with this block.
- Start to AW: the start edge enters FILL. With data already present, ADDR (and `m_awvalid`) is seen 2 cycles after the start edge.
- Write-through latency: a beat pushed at edge N is visible in `count` at N+1 and can drive `m_wdata` from cycle N+1.
- W throughput: one beat per cycle while `m_wready` is high.
- Zero-length transfer: `done` pulses 2 cycles after `cfg_start`, with no AXI traffic.
- The final burst is partial when `cfg_num_beats % BURST_LEN != 0`.

## Test plan
- **Basic:** base 0x1000, num 32, PU streams 32 beats of incrementing data with AXI always ready → two bursts: AW 0x1000 len 15, then 0x1080 len 15. `m_wlast` is high on beats 15 and 31. Data order matches the stream. `done` pulses once.
- **Partial burst:** num 20 → AW len 15 then len 3, second address base+0x80. `done` pulses after the second B.
- **Back-pressure:** hold `m_wready` at 0 while the PU streams → `stream_write_ready` falls when `count` reaches 63. With the 1-cycle-delayed PU req, `count` never exceeds 64 and `overflow` stays 0.
- **Overflow:** force 65 pushes with `m_wready` held at 0 → `overflow` is 1 and sticky; it clears on the next accepted `cfg_start`.
- **Edge cases:**
  - num 0 → `done` pulses 2 cycles after start, and `m_awvalid` never rises.
  - `cfg_start` while `busy` → ignored.
  - Reset during DATA → all outputs return to their reset values the next cycle.
